// File: rtl/vga_pkg.sv
// Shared video text definitions: character codes, menu FSM state type and
// the constant menu label table used by game_menu_txt.
package vga_pkg;

    typedef logic [6:0] char_t;

    localparam char_t CH_SPACE = 7'h20;
    localparam char_t CH_NKL   = 7'h5B;
    localparam char_t CH_NKR   = 7'h5D;
    localparam char_t CH_A     = 7'h41;
    localparam char_t CH_B     = 7'h42;
    localparam char_t CH_C     = 7'h43;
    localparam char_t CH_X     = 7'h58;

    typedef enum logic {BROWSE = 1'b0, LOCKED = 1'b1} menu_state_t;

    localparam int MENU_LABEL_W  = 12;
    localparam int MENU_MAX_ROWS = 16;
    localparam int MENU_N_SETS   = 2;

    typedef logic [MENU_N_SETS-1:0][MENU_MAX_ROWS-1:0][MENU_LABEL_W-1:0][6:0] label_tab_t;

    // Labels are written as fixed 12-char strings, first character in the MSBs.
    function automatic logic [8*MENU_LABEL_W-1:0] label_str(input int lset, input int row);
        logic [8*MENU_LABEL_W-1:0] s;
        s = "            ";
        if (lset == 0) begin
            case (row)
                0: s = "START GAME  ";
                1: s = "OPTIONS     ";
                2: s = "HIGH SCORES ";
                3: s = "QUIT        ";
                default: s = "            ";
            endcase
        end else if (lset == 1) begin
            case (row)
                0: s = "RESUME      ";
                1: s = "RESTART     ";
                2: s = "SOUND       ";
                3: s = "EXIT TO MENU";
                default: s = "            ";
            endcase
        end
        return s;
    endfunction

    function automatic label_tab_t build_labels();
        label_tab_t t;
        logic [8*MENU_LABEL_W-1:0] s;
        t = '0;
        for (int ls = 0; ls < MENU_N_SETS; ls++) begin
            for (int r = 0; r < MENU_MAX_ROWS; r++) begin
                s = label_str(ls, r);
                for (int c = 0; c < MENU_LABEL_W; c++)
                    t[ls][r][c] = s[8*(MENU_LABEL_W-1-c) +: 7];
            end
        end
        return t;
    endfunction

    localparam label_tab_t MENU_LABELS = build_labels();

endpackage

// File: rtl/game_menu_ctrl.sv
// Menu cursor/selection FSM. Marker blink counter is built only when
// GAME_MENU_BLINK_EN is defined; otherwise the marker is always visible.
module game_menu_ctrl
    import vga_pkg::*;
#(
    parameter int N_ITEMS      = 4,
    parameter int BLINK_FRAMES = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       frame_tick,
    input  logic       key_up,
    input  logic       key_down,
    input  logic       key_enter,
    input  logic       key_back,
    output logic [3:0] cursor_idx,
    output logic [3:0] sel_idx,
    output logic       sel_valid,
    output logic       locked,
    output logic       mark_vis
);

    localparam logic [3:0] LAST = 4'(N_ITEMS - 1);

    menu_state_t state, state_nx;
    logic confirm, mv_up, mv_dn, leave;

    // Enter beats up/down in BROWSE; opposing arrows cancel.
    always_comb begin
        confirm = (state == BROWSE) && key_enter;
        mv_up   = (state == BROWSE) && !key_enter && key_up && !key_down;
        mv_dn   = (state == BROWSE) && !key_enter && key_down && !key_up;
        leave   = (state == LOCKED) && key_back;
    end

    always_ff @(posedge clk) begin
        if (rst) state <= BROWSE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            BROWSE:  if (key_enter) state_nx = LOCKED;
            LOCKED:  if (key_back)  state_nx = BROWSE;
            default: state_nx = BROWSE;
        endcase
    end

    always_comb begin
        locked = (state == LOCKED);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cursor_idx <= '0;
            sel_idx    <= '0;
            sel_valid  <= 1'b0;
        end else begin
            sel_valid <= confirm;
            if (confirm) sel_idx <= cursor_idx;
            if (mv_up)   cursor_idx <= (cursor_idx == 4'd0) ? LAST : cursor_idx - 4'd1;
            if (mv_dn)   cursor_idx <= (cursor_idx == LAST) ? 4'd0 : cursor_idx + 4'd1;
        end
    end

`ifdef GAME_MENU_BLINK_EN
    localparam int CW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    logic [CW-1:0] blink_cnt;
    logic          blink_vis;

    // A move or return to BROWSE restarts the blink period with the marker shown.
    always_ff @(posedge clk) begin
        if (rst || mv_up || mv_dn || leave) begin
            blink_cnt <= '0;
            blink_vis <= 1'b1;
        end else if (frame_tick) begin
            if (blink_cnt == CW'(BLINK_FRAMES - 1)) begin
                blink_cnt <= '0;
                blink_vis <= ~blink_vis;
            end else begin
                blink_cnt <= blink_cnt + 1'b1;
            end
        end
    end

    assign mark_vis = locked | blink_vis;
`else
    logic unused_frame_tick;
    assign unused_frame_tick = frame_tick;
    assign mark_vis = 1'b1;
`endif

endmodule

// File: rtl/game_menu_txt.sv
// N-item menu text source: char_xy -> char_code/highlight with 1-clk latency.
// Optional marker blink enabled by defining GAME_MENU_BLINK_EN.
module game_menu_txt
    import vga_pkg::*;
#(
    parameter int    N_ITEMS      = 4,
    parameter int    LABEL_SET    = 0,
    parameter int    BLINK_FRAMES = 16,
    parameter char_t MARK_CODE    = CH_A
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       frame_tick,
    input  logic       key_up,
    input  logic       key_down,
    input  logic       key_enter,
    input  logic       key_back,
    input  logic [7:0] char_xy,
    output logic [6:0] char_code,
    output logic       highlight,
    output logic [3:0] cursor_idx,
    output logic [3:0] sel_idx,
    output logic       sel_valid,
    output logic       locked
);

    logic       mark_vis;
    logic [3:0] row, col;
    logic       in_range;
    char_t      code_nx;
    logic       hl_nx;

    game_menu_ctrl #(
        .N_ITEMS      (N_ITEMS),
        .BLINK_FRAMES (BLINK_FRAMES)
    ) u_ctrl (
        .clk        (clk),
        .rst        (rst),
        .frame_tick (frame_tick),
        .key_up     (key_up),
        .key_down   (key_down),
        .key_enter  (key_enter),
        .key_back   (key_back),
        .cursor_idx (cursor_idx),
        .sel_idx    (sel_idx),
        .sel_valid  (sel_valid),
        .locked     (locked),
        .mark_vis   (mark_vis)
    );

    assign row      = char_xy[7:4];
    assign col      = char_xy[3:0];
    assign in_range = ({1'b0, row} < 5'(N_ITEMS));

    // Uses the cursor/FSM state of the same cycle the cell address arrives.
    always_comb begin
        code_nx = CH_SPACE;
        hl_nx   = 1'b0;
        if (in_range) begin
            hl_nx = locked && (row == sel_idx);
            case (col)
                4'd0:    code_nx = CH_NKL;
                4'd1:    code_nx = (row == cursor_idx && mark_vis) ? MARK_CODE : CH_SPACE;
                4'd2:    code_nx = CH_NKR;
                4'd3:    code_nx = CH_SPACE;
                default: code_nx = MENU_LABELS[LABEL_SET][row][col - 4'd4];
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            char_code <= CH_SPACE;
            highlight <= 1'b0;
        end else begin
            char_code <= code_nx;
            highlight <= hl_nx;
        end
    end

endmodule

// File: tb/tb_game_menu_txt.sv
// Directed + randomized bench for game_menu_txt against a behavioural menu model.
module tb_game_menu_txt;
    import vga_pkg::*;

    localparam int N  = 4;
    localparam int BF = 2;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       frame_tick = 1'b0;
    logic       key_up = 1'b0, key_down = 1'b0, key_enter = 1'b0, key_back = 1'b0;
    logic [7:0] char_xy = 8'h00;
    logic [6:0] char_code;
    logic       highlight;
    logic [3:0] cursor_idx, sel_idx;
    logic       sel_valid, locked;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    game_menu_txt #(
        .N_ITEMS      (N),
        .LABEL_SET    (0),
        .BLINK_FRAMES (BF),
        .MARK_CODE    (CH_A)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .frame_tick (frame_tick),
        .key_up     (key_up),
        .key_down   (key_down),
        .key_enter  (key_enter),
        .key_back   (key_back),
        .char_xy    (char_xy),
        .char_code  (char_code),
        .highlight  (highlight),
        .cursor_idx (cursor_idx),
        .sel_idx    (sel_idx),
        .sel_valid  (sel_valid),
        .locked     (locked)
    );

    // Reference menu text for label set 0; shorter labels are space-padded.
    string labels [N] = '{"START GAME", "OPTIONS", "HIGH SCORES", "QUIT"};

    int m_cur, m_sel, m_cnt;
    bit m_lock, m_sv, m_vis;

    task automatic model_reset();
        m_cur = 0; m_sel = 0; m_cnt = 0;
        m_lock = 0; m_sv = 0; m_vis = 1;
    endtask

    function automatic logic [6:0] exp_char(input logic [7:0] xy);
        int r, c;
        byte b;
        r = int'(xy[7:4]);
        c = int'(xy[3:0]);
        if (r >= N) return CH_SPACE;
        if (c == 0) return CH_NKL;
        if (c == 1) return (r == m_cur && (m_vis || m_lock)) ? CH_A : CH_SPACE;
        if (c == 2) return CH_NKR;
        if (c == 3) return CH_SPACE;
        if (c - 4 >= labels[r].len()) return CH_SPACE;
        b = labels[r][c-4];
        return b[6:0];
    endfunction

    task automatic model_step(input bit u, input bit d, input bit e, input bit b, input bit ft);
        bit moved, back_to_browse;
        moved = 0; back_to_browse = 0; m_sv = 0;
        if (!m_lock) begin
            if (e) begin
                m_lock = 1; m_sel = m_cur; m_sv = 1;
            end else if (u && !d) begin
                m_cur = (m_cur + N - 1) % N; moved = 1;
            end else if (d && !u) begin
                m_cur = (m_cur + 1) % N; moved = 1;
            end
        end else if (b) begin
            m_lock = 0; back_to_browse = 1;
        end
`ifdef GAME_MENU_BLINK_EN
        if (moved || back_to_browse) begin
            m_cnt = 0; m_vis = 1;
        end else if (ft) begin
            m_cnt++;
            if (m_cnt == BF) begin m_cnt = 0; m_vis = !m_vis; end
        end
`else
        if (moved || back_to_browse || ft) m_vis = 1;
`endif
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step(input bit u, input bit d, input bit e, input bit b,
                        input logic [7:0] xy, input bit ft = 0, input bit r = 0);
        logic [6:0] ec;
        bit eh;
        @(negedge clk);
        key_up = u; key_down = d; key_enter = e; key_back = b;
        char_xy = xy; frame_tick = ft; rst = r;
        ec = exp_char(xy);
        eh = m_lock && (int'(xy[7:4]) == m_sel) && (int'(xy[7:4]) < N);
        if (r) begin
            model_reset();
            ec = CH_SPACE; eh = 0;
        end else begin
            model_step(u, d, e, b, ft);
        end
        @(posedge clk);
        #1;
        chk("char_code",  {1'b0, char_code},    {1'b0, ec});
        chk("highlight",  {7'b0, highlight},    {7'b0, eh});
        chk("cursor_idx", {4'b0, cursor_idx},   8'(m_cur));
        chk("sel_idx",    {4'b0, sel_idx},      8'(m_sel));
        chk("sel_valid",  {7'b0, sel_valid},    {7'b0, m_sv});
        chk("locked",     {7'b0, locked},       {7'b0, m_lock});
    endtask

    initial begin
        model_reset();
        step(0,0,0,0, 8'h00, 0, 1);
        step(0,0,0,0, 8'h00);
        step(0,0,0,0, 8'h01);
        step(0,0,0,0, 8'h02);
        step(0,0,0,0, 8'h11);
        // Wrap upward from row 0, then back down.
        step(1,0,0,0, 8'h05);
        step(0,0,0,0, 8'h31);
        step(0,0,0,0, 8'h01);
        step(0,1,0,0, 8'h00);
        step(0,1,0,0, 8'h21);
        step(0,1,0,0, 8'h21);
        step(1,1,0,0, 8'h21);
        // Enter wins over down; sel_valid lasts one cycle.
        step(0,1,1,0, 8'h21);
        step(0,0,0,0, 8'h21);
        step(0,1,0,0, 8'h21);
        for (int i = 0; i < 16; i++) step(0,0,0,0, 8'h20 + 8'(i));
        step(0,0,0,0, 8'h10);
        step(1,1,1,1, 8'h2F);
        step(0,0,0,0, 8'h20);
        step(0,0,1,0, 8'h04);
        step(0,0,1,0, 8'h21, 0, 1);
        step(0,0,0,0, 8'h01);
`ifdef GAME_MENU_BLINK_EN
        for (int f = 0; f < 4; f++) step(0,0,0,0, 8'h01, 1);
        step(0,0,0,0, 8'h01);
        step(0,0,0,0, 8'h01, 1);
        step(0,0,0,0, 8'h01, 1);
        step(0,1,0,0, 8'h01);
        step(0,0,0,0, 8'h11);
`endif
        for (int i = 0; i < 600; i++) begin
            step(($urandom_range(0,5) == 0), ($urandom_range(0,5) == 0),
                 ($urandom_range(0,9) == 0), ($urandom_range(0,5) == 0),
                 8'($urandom_range(0,255)), ($urandom_range(0,3) == 0),
                 ($urandom_range(0,60) == 0));
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
